amba_arbiter_rr: RTL and testbench
==================================

// Module: amba_arbiter_rr
// PURPOSE
//   Round-robin AHB bus arbiter; shares the single AHB slave path (FIFO slave, memory slaves)
//   between NMASTER masters. Drives one-hot grant and address-/data-phase owner indices
//   for the external haddr/hwdata muxes. Caps bus tenure so no master starves the FIFO.
// PARAMETERS
//   NMASTER    2   number of requesting masters, 2..8
//   MAX_BEATS  4   max accepted transfers per tenure while another master requests, >=1
//   DEF_MASTER 0   master parked on the bus when nobody requests
// PORTS
//   clk            in   1              system clock, all logic on rising edge
//   rst_n          in   1              synchronous active-low reset
//   hbusreq        in   NMASTER        per-master bus request, level
//   htrans         in   2              htrans of current address-phase owner (post-mux)
//   hready         in   1              bus-wide hready from slave mux
//   hgrant         out  NMASTER        one-hot grant, registered
//   hmaster        out  $clog2(NMASTER) address-phase owner index
//   hmaster_data   out  $clog2(NMASTER) data-phase owner index (hwdata mux select)
//   busy           out  1              1 while a requesting master holds the grant
// BEHAVIOUR
//   Reset (rst_n=0 at posedge): hgrant=one-hot(DEF_MASTER), hmaster=hmaster_data=DEF_MASTER,
//     busy=0, beat_cnt=0, rr_ptr=DEF_MASTER. Reset mid-transfer aborts tenure, no grant held.
//   FSM: PARK (default master, no request) / OWN (granted master requesting) / HANDOFF.
//   Beat: cycle with hready=1 and htrans in {NONSEQ,SEQ}; beat_cnt increments, saturates
//     at MAX_BEATS; cleared on every grant change.
//   Rearbitration point: hready=1 AND any of: owner hbusreq=0; htrans=IDLE with other
//     requests pending; beat_cnt=MAX_BEATS-1 with this beat accepted and another request.
//   Winner: first requester at or after rr_ptr+1 (modulo NMASTER); rr_ptr <= winner.
//     Current owner wins only if it is the sole requester. No requester -> DEF_MASTER, PARK.
//   hgrant/hmaster update on the clock edge after the rearbitration point (1-cycle latency,
//     AHB: new owner drives address phase in the next hready cycle).
//   hmaster_data <= hmaster on every posedge with hready=1; held while hready=0.
//   hready=0: grant, hmaster, hmaster_data, beat_cnt, rr_ptr all frozen (no handoff in stall).
//   Simultaneous requests at reset release: rr_ptr=DEF_MASTER -> DEF_MASTER+1 served first.
//   busy = (state==OWN). BUSY htrans counts as non-beat; does not advance beat_cnt.
//   hbusreq bits >= NMASTER do not exist; hgrant always exactly one-hot.
// CONFIGURATION
//   AMBA_ARB_LOCK_EN defined: adds input hlock [NMASTER] (per-master lock). While owner's
//     hlock=1 the MAX_BEATS and IDLE-with-pending rearbitration are suppressed; only
//     owner hbusreq=0 releases. hlock sampled with hbusreq.
//   Not defined: no hlock port; tenure always limited by MAX_BEATS.
// TESTING
//   Reset: rst_n=0 2 cycles, hbusreq=2'b11 -> hgrant=01, hmaster=0, busy=0 during reset.
//   Single requester: hbusreq=10, NONSEQ+7 SEQ, hready=1 -> hgrant=10 after 1 cycle, holds
//     all 8 beats, hmaster_data trails hmaster by 1 hready cycle.
//   Contention, MAX_BEATS=4: both request, continuous SEQ -> grant alternates 10,01,10 every
//     4 beats; each master gets exactly 4 beats per tenure.
//   Stall: hready=0 for 3 cycles on 4th beat -> no handoff until hready=1, then grant moves.
//   Release/park: owner drops hbusreq with other idle -> hgrant=one-hot(DEF_MASTER), busy=0.
//   Lock (AMBA_ARB_LOCK_EN): master1 hlock=1, master0 requesting, 10 beats -> hgrant stays
//     10 until hbusreq[1]=0, then 01 next cycle.

Source files
------------

// File: rtl/amba_arbiter_rr.sv
// -----------------------------------------------------------------------------
// amba_arbiter_rr
//   Round-robin AHB bus arbiter. Shares one AHB slave path between NMASTER
//   masters, drives a registered one-hot grant plus the address-phase and
//   data-phase owner indices that steer the external haddr/hwdata muxes.
//   While another master is waiting, a tenure is capped at MAX_BEATS
//   accepted transfers so no single master can starve the others.
//
//   Optional feature (macro AMBA_ARB_LOCK_EN): adds a per-master hlock input.
//   While the current owner holds hlock, neither the beat cap nor an IDLE
//   with other requests pending ends its tenure; only dropping hbusreq does.
//
// Parameters
//   NMASTER     number of requesting masters (2..8)
//   MAX_BEATS   accepted transfers per tenure while others request (>=1)
//   DEF_MASTER  master parked on the bus when nobody requests
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   hbusreq       per-master level request
//   hlock         per-master lock (only with AMBA_ARB_LOCK_EN)
//   htrans        htrans of the current address-phase owner (post-mux)
//   hready        bus-wide hready
//   hgrant        one-hot grant, registered
//   hmaster       address-phase owner index
//   hmaster_data  data-phase owner index (hwdata mux select)
//   busy          1 while a requesting master holds the grant
// -----------------------------------------------------------------------------
module amba_arbiter_rr #(
   parameter int NMASTER    = 2,
   parameter int MAX_BEATS  = 4,
   parameter int DEF_MASTER = 0
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NMASTER-1:0]         hbusreq,
`ifdef AMBA_ARB_LOCK_EN
   input  logic [NMASTER-1:0]         hlock,
`endif
   input  logic [1:0]                 htrans,
   input  logic                       hready,
   output logic [NMASTER-1:0]         hgrant,
   output logic [$clog2(NMASTER)-1:0] hmaster,
   output logic [$clog2(NMASTER)-1:0] hmaster_data,
   output logic                       busy
);

   localparam int IW = $clog2(NMASTER);
   localparam int BW = $clog2(MAX_BEATS + 1);

   localparam logic [1:0] HTRANS_IDLE = 2'b00;

   // PARK: default master holds the bus for nobody.
   // OWN: a requesting master holds the bus.
   // HANDOFF: owner's tenure is over but hready=0 freezes the grant; the
   //   move happens on the first hready=1 edge.
   typedef enum logic [1:0] {PARK, OWN, HANDOFF} state_t;

   state_t               state_reg, state_next;
   logic [NMASTER-1:0]   hgrant_reg, grant_next;
   logic [IW-1:0]        hmaster_reg, hmaster_data_reg;
   logic [IW-1:0]        rr_ptr_reg, win_idx;
   logic [BW-1:0]        beat_cnt_reg;
   logic [IW:0]          cand;
   logic                 found;
   logic                 owner_req, other_req, owner_lock;
   logic                 xfer, beat, idle_hit, limit_hit;
   logic                 rearb_cond, rearb;

   assign owner_req = |(hbusreq & hgrant_reg);
   assign other_req = |(hbusreq & ~hgrant_reg);
`ifdef AMBA_ARB_LOCK_EN
   assign owner_lock = |(hlock & hgrant_reg);
`else
   assign owner_lock = 1'b0;
`endif

   // NONSEQ (10) and SEQ (11) are the only transfer types that count as beats
   assign xfer = htrans[1];
   assign beat = hready & xfer;

   assign idle_hit  = other_req & (htrans == HTRANS_IDLE) & ~owner_lock;
   // A saturated counter also forces a yield, so a master that ran alone
   // past the cap still gives up the bus as soon as someone else asks.
   assign limit_hit = other_req & ~owner_lock &
                      ((beat_cnt_reg == BW'(MAX_BEATS)) |
                       ((beat_cnt_reg == BW'(MAX_BEATS - 1)) & xfer));

   // Tenure-ending condition, evaluated independent of hready so a stalled
   // handoff can be flagged; it only takes effect on an hready cycle.
   assign rearb_cond = ~owner_req | idle_hit | limit_hit;
   assign rearb      = hready & ((state_reg == PARK) | rearb_cond);

   // Round-robin search starting one past the last winner; the last winner
   // is therefore checked last and only wins when it is the sole requester.
   always_comb begin
      found   = 1'b0;
      win_idx = IW'(DEF_MASTER);
      cand    = '0;
      for (int k = 1; k <= NMASTER; k++) begin
         cand = {1'b0, rr_ptr_reg} + (IW+1)'(k);
         if (cand >= (IW+1)'(NMASTER))
            cand = cand - (IW+1)'(NMASTER);
         if (!found && hbusreq[cand[IW-1:0]]) begin
            found   = 1'b1;
            win_idx = cand[IW-1:0];
         end
      end
   end

   for (genvar gi = 0; gi < NMASTER; gi++) begin : g_onehot
      assign grant_next[gi] = (win_idx == IW'(gi));
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state_reg <= PARK;
      else
         state_reg <= state_next;
   end

   // FSM next-state logic
   always_comb begin
      state_next = state_reg;
      if (!hready) begin
         if (state_reg != PARK)
            state_next = rearb_cond ? HANDOFF : OWN;
      end else if (rearb) begin
         state_next = found ? OWN : PARK;
      end else begin
         state_next = OWN;
      end
   end

   // FSM outputs
   always_comb begin
      busy = (state_reg == OWN);
   end

   // Grant, owner pipeline, beat counter and round-robin pointer; all of it
   // is frozen while hready=0.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hgrant_reg       <= NMASTER'(1) << DEF_MASTER;
         hmaster_reg      <= IW'(DEF_MASTER);
         hmaster_data_reg <= IW'(DEF_MASTER);
         beat_cnt_reg     <= '0;
         rr_ptr_reg       <= IW'(DEF_MASTER);
      end else if (hready) begin
         hmaster_data_reg <= hmaster_reg;
         if (rearb) begin
            hgrant_reg   <= grant_next;
            hmaster_reg  <= win_idx;
            beat_cnt_reg <= '0;
            if (found)
               rr_ptr_reg <= win_idx;
         end else if (beat && (beat_cnt_reg != BW'(MAX_BEATS))) begin
            beat_cnt_reg <= beat_cnt_reg + BW'(1);
         end
      end
   end

   assign hgrant       = hgrant_reg;
   assign hmaster      = hmaster_reg;
   assign hmaster_data = hmaster_data_reg;

endmodule

// File: tb/tb_amba_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_amba_arbiter_rr
//   Bench for amba_arbiter_rr. dut0 uses the default parameters and is
//   driven through a vector table plus hand-written corner sequences; dut1
//   (3 masters, cap of 2 beats, parked on master 1) shares the stimulus.
//   Both are compared every cycle against a behavioural model during the
//   random phase, dut1 throughout.
// -----------------------------------------------------------------------------
module tb_amba_arbiter_rr;

`ifdef AMBA_ARB_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] req = 3'b000;
   logic [2:0] lock = 3'b000;
   logic [1:0] tr = 2'b00;
   logic       hr = 1'b1;

   logic [1:0] g0;
   logic [0:0] hm0, hmd0;
   logic       busy0;
   logic [2:0] g1;
   logic [1:0] hm1, hmd1;
   logic       busy1;

   int errors = 0;
   int checks = 0;
   bit cmp0 = 1'b0;

   always #5 clk = ~clk;

   amba_arbiter_rr #(.NMASTER(2), .MAX_BEATS(4), .DEF_MASTER(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .hbusreq(req[1:0]),
`ifdef AMBA_ARB_LOCK_EN
      .hlock(lock[1:0]),
`endif
      .htrans(tr), .hready(hr), .hgrant(g0), .hmaster(hm0),
      .hmaster_data(hmd0), .busy(busy0)
   );

   amba_arbiter_rr #(.NMASTER(3), .MAX_BEATS(2), .DEF_MASTER(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .hbusreq(req),
`ifdef AMBA_ARB_LOCK_EN
      .hlock(lock),
`endif
      .htrans(tr), .hready(hr), .hgrant(g1), .hmaster(hm1),
      .hmaster_data(hmd1), .busy(busy1)
   );

   // ---------------- behavioural reference model ----------------
   int  m_own[2], m_cnt[2], m_ptr[2], m_hd[2];
   bit  m_park[2], m_pend[2];

   function automatic int nm(int u); return (u == 0) ? 2 : 3; endfunction
   function automatic int mb(int u); return (u == 0) ? 4 : 2; endfunction
   function automatic int dm(int u); return (u == 0) ? 0 : 1; endfunction

   // Advance model u by one clock edge using the inputs currently driven.
   task automatic model_step(input int u);
      int n, o, w;
      bit others, xf, lk, sw, found;
      n = nm(u);
      w = dm(u);
      if (!rst_n) begin
         m_own[u] = dm(u); m_park[u] = 1'b1; m_cnt[u] = 0;
         m_ptr[u] = dm(u); m_hd[u] = dm(u); m_pend[u] = 1'b0;
         return;
      end
      o = m_own[u];
      others = 1'b0;
      for (int j = 0; j < n; j++)
         if (j != o && req[j]) others = 1'b1;
      xf = (tr == 2'b10) || (tr == 2'b11);
      lk = LOCK_EN && lock[o];
      // tenure over: owner gone, or someone waits and the owner idles or
      // has used (or is now using) its last allowed beat
      sw = !req[o] || (others && !lk &&
           (tr == 2'b00 || m_cnt[u] == mb(u) || (m_cnt[u] == mb(u) - 1 && xf)));
      if (!hr) begin
         m_pend[u] = !m_park[u] && sw;
         return;
      end
      m_hd[u] = o;
      m_pend[u] = 1'b0;
      if (m_park[u] || sw) begin
         found = 1'b0;
         for (int k = 1; k <= n; k++)
            if (!found && req[(m_ptr[u] + k) % n]) begin
               found = 1'b1;
               w = (m_ptr[u] + k) % n;
            end
         if (found) begin
            m_own[u] = w; m_ptr[u] = w; m_park[u] = 1'b0;
         end else begin
            m_own[u] = dm(u); m_park[u] = 1'b1;
         end
         m_cnt[u] = 0;
      end else if (xf && m_cnt[u] < mb(u)) begin
         m_cnt[u] = m_cnt[u] + 1;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_models(input int cyc);
      chk($sformatf("u1_grant@%0d", cyc), int'(g1), 1 << m_own[1]);
      chk($sformatf("u1_hmaster@%0d", cyc), int'(hm1), m_own[1]);
      chk($sformatf("u1_hmdata@%0d", cyc), int'(hmd1), m_hd[1]);
      chk($sformatf("u1_busy@%0d", cyc), int'(busy1), int'(!m_park[1] && !m_pend[1]));
      if (cmp0) begin
         chk($sformatf("u0_grant@%0d", cyc), int'(g0), 1 << m_own[0]);
         chk($sformatf("u0_hmaster@%0d", cyc), int'(hm0), m_own[0]);
         chk($sformatf("u0_hmdata@%0d", cyc), int'(hmd0), m_hd[0]);
         chk($sformatf("u0_busy@%0d", cyc), int'(busy0), int'(!m_park[0] && !m_pend[0]));
      end
   endtask

   int cyc = 0;

   // One clock: update models from the driven inputs, take the edge,
   // sample outputs 1 time unit later.
   task automatic cycle();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      cyc++;
      chk_models(cyc);
   endtask

   // ---------------- directed vector table for dut0 ----------------
   typedef struct {
      logic       rst_n;
      logic [1:0] req;
      logic [1:0] tr;
      logic       hr;
      logic [1:0] g;
      int         hm;
      int         hmd;
      logic       busy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [1:0] q, input logic [1:0] t,
                      input logic h, input logic [1:0] g, input int m,
                      input int md, input logic b);
      vec_t v;
      v.rst_n = r; v.req = q; v.tr = t; v.hr = h;
      v.g = g; v.hm = m; v.hmd = md; v.busy = b;
      tbl.push_back(v);
   endtask

   initial begin
      // reset with both requesting: parked on master 0
      repeat (2) add(1'b0, 2'b11, 2'b00, 1'b1, 2'b01, 0, 0, 1'b0);
      // contention, continuous SEQ: master 1 first, 4 beats each
      add(1'b1, 2'b11, 2'b11, 1'b1, 2'b10, 1, 0, 1'b1);
      repeat (3) add(1'b1, 2'b11, 2'b11, 1'b1, 2'b10, 1, 1, 1'b1);
      add(1'b1, 2'b11, 2'b11, 1'b1, 2'b01, 0, 1, 1'b1);
      repeat (3) add(1'b1, 2'b11, 2'b11, 1'b1, 2'b01, 0, 0, 1'b1);
      add(1'b1, 2'b11, 2'b11, 1'b1, 2'b10, 1, 0, 1'b1);
      repeat (3) add(1'b1, 2'b11, 2'b11, 1'b1, 2'b10, 1, 1, 1'b1);
      // 3-cycle stall on the 4th beat: grant frozen, then moves
      repeat (3) add(1'b1, 2'b11, 2'b11, 1'b0, 2'b10, 1, 1, 1'b0);
      add(1'b1, 2'b11, 2'b11, 1'b1, 2'b01, 0, 1, 1'b1);
      // owner releases, nobody else: park on master 0
      repeat (2) add(1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 0, 0, 1'b0);
      // single requester: NONSEQ + 7 SEQ all held by master 1
      add(1'b1, 2'b10, 2'b10, 1'b1, 2'b10, 1, 0, 1'b1);
      add(1'b1, 2'b10, 2'b10, 1'b1, 2'b10, 1, 1, 1'b1);
      repeat (7) add(1'b1, 2'b10, 2'b11, 1'b1, 2'b10, 1, 1, 1'b1);
      add(1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 0, 1, 1'b0);
      add(1'b1, 2'b00, 2'b00, 1'b1, 2'b01, 0, 0, 1'b0);
      // both request from park (pointer at 1 -> master 0), IDLE hands over
      add(1'b1, 2'b11, 2'b00, 1'b1, 2'b01, 0, 0, 1'b1);
      add(1'b1, 2'b11, 2'b00, 1'b1, 2'b10, 1, 0, 1'b1);
      // BUSY transfers are not beats and do not end the tenure
      repeat (2) add(1'b1, 2'b11, 2'b01, 1'b1, 2'b10, 1, 1, 1'b1);

      for (int i = 0; i < tbl.size(); i++) begin
         rst_n = tbl[i].rst_n;
         req   = {1'b0, tbl[i].req};
         tr    = tbl[i].tr;
         hr    = tbl[i].hr;
         lock  = 3'b000;
         cycle();
         $display("row %0d: req=%b htrans=%b hready=%b -> hgrant=%b hmaster=%0d hmaster_data=%0d busy=%b",
                  i, req[1:0], tr, hr, g0, hm0, hmd0, busy0);
         chk($sformatf("tbl%0d_grant", i), int'(g0), int'(tbl[i].g));
         chk($sformatf("tbl%0d_hmaster", i), int'(hm0), tbl[i].hm);
         chk($sformatf("tbl%0d_hmdata", i), int'(hmd0), tbl[i].hmd);
         chk($sformatf("tbl%0d_busy", i), int'(busy0), int'(tbl[i].busy));
      end

      // reset in the middle of a tenure drops the grant back to park
      req = 3'b011; tr = 2'b11; hr = 1'b1;
      cycle();
      chk("midrst_pre_grant", int'(g0), 2);
      rst_n = 1'b0;
      cycle();
      $display("mid-transfer reset: hgrant=%b busy=%b", g0, busy0);
      chk("midrst_grant", int'(g0), 1);
      chk("midrst_hmaster", int'(hm0), 0);
      chk("midrst_busy", int'(busy0), 0);
      rst_n = 1'b1; req = 3'b000; tr = 2'b00;
      cycle();
      chk("midrst_park_grant", int'(g0), 1);

`ifdef AMBA_ARB_LOCK_EN
      // locked master 1 keeps the bus through 10 beats despite master 0
      req = 3'b011; lock = 3'b010; tr = 2'b11;
      cycle();
      chk("lock_first_grant", int'(g0), 2);
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk($sformatf("lock_hold%0d", i), int'(g0), 2);
      end
      req = 3'b001;
      cycle();
      $display("lock released: hgrant=%b", g0);
      chk("lock_release_grant", int'(g0), 1);
      lock = 3'b000;
`endif

      // random phase: both DUTs against the model every cycle
      cmp0 = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rst_n = ($urandom_range(0, 59) != 0);
         req   = 3'($urandom_range(0, 7));
         tr    = 2'($urandom_range(0, 3));
         hr    = ($urandom_range(0, 3) != 0);
         lock  = 3'($urandom_range(0, 7));
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
